// File: rtl/exc_sequencer.sv
// exc_sequencer: CP0 exception/eret sequencer (stall, flush, strobe, fetch redirect).
// Define EXC_PENDING_EN to add a single-entry slot holding a request that arrives mid-sequence.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_syscall,
  input  logic        req_break,
  input  logic        req_teq,
  input  logic [31:0] req_pc,
  input  logic        eret_req,
  input  logic [31:0] status,
  input  logic [31:0] epc_in,
  output logic        exception,
  output logic [3:0]  cause,
  output logic [31:0] exc_pc,
  output logic        eret,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, FLUSH, ISSUE, HANDLER, ERET} state_t;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cause_q, cause_d, req_cause;
  logic [31:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
  logic exception_q, eret_q, stall_q, flush_q, redirect_valid_q, busy_q;
  logic unused_status;
  assign unused_status = ^status[31:4];
`ifdef EXC_PENDING_EN
  logic pend_q, pend_d;
  logic [3:0] pcause_q, pcause_d;
  logic [31:0] ppc_q, ppc_d;
`endif
  // Cause code 0 doubles as "no enabled request".
  always_comb
    req_cause = !status[0]                ? 4'd0 :
                (req_syscall && status[1]) ? 4'b1000 :
                (req_break && status[2])   ? 4'b1001 :
                (req_teq && status[3])     ? 4'b1101 : 4'd0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cause_d = cause_q;
    pc_d = pc_q;
`ifdef EXC_PENDING_EN
    pend_d = pend_q;
    pcause_d = pcause_q;
    ppc_d = ppc_q;
    if ((state_q == FLUSH || (state_q == HANDLER && !eret_req)) && !pend_q && req_cause != 4'd0) begin
      pend_d = 1'b1;
      pcause_d = req_cause;
      ppc_d = req_pc + 32'd4;
    end
`endif
    case (state_q)
      IDLE: if (req_cause != 4'd0) begin
        state_d = FLUSH;
        cnt_d = CNT_INIT;
        cause_d = req_cause;
        pc_d = req_pc + 32'd4;
      end
      FLUSH: if (cnt_q == 4'd0) state_d = ISSUE; else cnt_d = cnt_q - 4'd1;
      ISSUE: state_d = HANDLER;
      HANDLER: if (eret_req) state_d = ERET;
      ERET: begin
        state_d = IDLE;
`ifdef EXC_PENDING_EN
        if (pend_q) begin
          state_d = FLUSH;
          cnt_d = CNT_INIT;
          cause_d = pcause_q;
          pc_d = ppc_q;
          pend_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    redirect_pc_d = (state_d == ISSUE) ? HANDLER_ADDR : (state_d == ERET) ? epc_in : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cause_q <= '0;
      pc_q <= '0;
      exception_q <= 1'b0;
      eret_q <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q <= '0;
      busy_q <= 1'b0;
`ifdef EXC_PENDING_EN
      pend_q <= 1'b0;
      pcause_q <= '0;
      ppc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cause_q <= cause_d;
      pc_q <= pc_d;
      exception_q <= state_d == ISSUE;
      eret_q <= state_d == ERET;
      stall_q <= state_d == FLUSH;
      flush_q <= state_d == FLUSH;
      redirect_valid_q <= state_d == ISSUE || state_d == ERET;
      redirect_pc_q <= redirect_pc_d;
      busy_q <= state_d != IDLE;
`ifdef EXC_PENDING_EN
      pend_q <= pend_d;
      pcause_q <= pcause_d;
      ppc_q <= ppc_d;
`endif
    end
  end
  assign exception = exception_q;
  assign cause = cause_q;
  assign exc_pc = pc_q;
  assign eret = eret_q;
  assign stall = stall_q;
  assign flush = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc = redirect_pc_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed stimulus, timestamp-based reference model checked every cycle.
module tb_exc_sequencer;
  localparam int FC = 2;
  localparam logic [31:0] HA = 32'h00400004;
  logic clk = 1'b0, rst = 1'b1;
  logic req_syscall = 0, req_break = 0, req_teq = 0, eret_req = 0;
  logic [31:0] req_pc = 0, status = 0, epc_in = 0;
  logic exception, eret, stall, flush, redirect_valid, busy;
  logic [3:0] cause;
  logic [31:0] exc_pc, redirect_pc;
  int tests = 0, fails = 0;
  bit chk_on = 0;

  exc_sequencer #(.HANDLER_ADDR(HA), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .req_syscall(req_syscall), .req_break(req_break), .req_teq(req_teq),
    .req_pc(req_pc), .eret_req(eret_req), .status(status), .epc_in(epc_in),
    .exception(exception), .cause(cause), .exc_pc(exc_pc), .eret(eret), .stall(stall),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [3:0] pick(input logic [31:0] st, input logic s, input logic b, input logic t);
    if (!st[0]) return 4'd0;
    if (s && st[1]) return 4'b1000;
    if (b && st[2]) return 4'b1001;
    if (t && st[3]) return 4'b1101;
    return 4'd0;
  endfunction

  // Model: an accepted request at edge t0 gives FC stall cycles, then the strobe; eret at edge teret.
  int n = 0, t0 = 0, teret = -1;
  bit act = 0, pend = 0;
  logic [3:0] m_cause = 0, p_cause = 0, rc;
  logic [31:0] m_pc = 0, p_pc = 0, m_epc = 0;
  logic e_stall = 0, e_exc = 0, e_eret = 0, e_busy = 0;
  logic [31:0] e_rpc = 0;
  always @(posedge clk) begin
    n++;
    rc = pick(status, req_syscall, req_break, req_teq);
    if (rst) begin
      act = 0; teret = -1; pend = 0; m_cause = 0; m_pc = 0;
    end else if (act && teret >= 0) begin
      act = 0; teret = -1;
`ifdef EXC_PENDING_EN
      if (pend) begin act = 1; t0 = n; m_cause = p_cause; m_pc = p_pc; pend = 0; end
`endif
    end else if (act) begin
      if (n - 1 - t0 > FC && eret_req) begin teret = n; m_epc = epc_in; end
`ifdef EXC_PENDING_EN
      else if (n - 1 - t0 != FC && !pend && rc != 0) begin pend = 1; p_cause = rc; p_pc = req_pc + 32'd4; end
`endif
    end else if (rc != 0) begin
      act = 1; t0 = n; m_cause = rc; m_pc = req_pc + 32'd4;
    end
    e_stall = act && teret < 0 && n - t0 < FC;
    e_exc = act && teret < 0 && n - t0 == FC;
    e_eret = act && teret == n;
    e_busy = act;
    e_rpc = e_exc ? HA : e_eret ? m_epc : 32'd0;
  end

  always @(negedge clk) if (chk_on) begin
    chk("exception", exception, e_exc);
    chk("eret", eret, e_eret);
    chk("stall", stall, e_stall);
    chk("flush", flush, e_stall);
    chk("redirect_valid", redirect_valid, e_exc | e_eret);
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("busy", busy, e_busy);
    chk("cause", cause, m_cause);
    chk("exc_pc", exc_pc, m_pc);
  end

  task automatic tick(); @(negedge clk); endtask
  task automatic do_eret(input logic [31:0] epc);
    epc_in = epc; eret_req = 1; tick(); eret_req = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0; chk_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_exc_pc", exc_pc, 0);
    // syscall with full enable
    status = 32'hF; req_pc = 32'h00400100; req_syscall = 1; tick(); req_syscall = 0;
    chk("t1_stall1", stall, 1); tick();
    chk("t1_flush2", flush, 1); tick();
    chk("t1_exc", exception, 1);
    chk("t1_cause", cause, 4'b1000);
    chk("t1_exc_pc", exc_pc, 32'h00400104);
    chk("t1_rpc", redirect_pc, HA);
    tick();
    do_eret(32'h00400100);
    chk("t1_eret", eret, 1);
    chk("t1_eret_rv", redirect_valid, 1);
    chk("t1_eret_rpc", redirect_pc, 32'h00400100);
    tick();
    chk("t1_idle", busy, 0);
    eret_req = 1; tick(); eret_req = 0;
    chk("idle_eret", eret, 0);
    tick();
    // break beats teq
    req_break = 1; req_teq = 1; req_pc = 32'h10; tick(); req_break = 0; req_teq = 0;
    tick(); tick();
    chk("t2_exc", exception, 1);
    chk("t2_cause", cause, 4'b1001);
    chk("t2_exc_pc", exc_pc, 32'h14);
    tick();
    do_eret(32'h10); tick(); tick();
    chk("t2_idle", busy, 0);
    // masking
    status = 32'h7; req_teq = 1; tick(); req_teq = 0;
    chk("mask_teq_busy", busy, 0);
    chk("mask_teq_stall", stall, 0);
    status = 32'hE; req_syscall = 1; tick(); req_syscall = 0;
    chk("mask_ge_busy", busy, 0);
    repeat (3) tick();
    // pc wrap
    status = 32'hF; req_pc = 32'hFFFFFFFC; req_syscall = 1; tick(); req_syscall = 0;
    tick(); tick();
    chk("wrap_exc", exception, 1);
    chk("wrap_pc", exc_pc, 32'h0);
    tick();
    do_eret(32'h0); tick(); tick();
    // reset in second flush cycle
    req_pc = 32'h200; req_syscall = 1; tick(); req_syscall = 0;
    tick();
    rst = 1; tick(); rst = 0;
    chk("abort_exc", exception, 0);
    chk("abort_stall", stall, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pc", exc_pc, 0);
    chk("abort_cause", cause, 0);
    tick(); tick();
    // request during handler, then eret
    req_pc = 32'h300; req_syscall = 1; tick(); req_syscall = 0;
    tick(); tick(); tick();
    req_teq = 1; req_pc = 32'h500; tick(); req_teq = 0;
    do_eret(32'h304);
    chk("pend_eret", eret, 1);
    tick(); tick(); tick();
`ifdef EXC_PENDING_EN
    chk("pend_exc", exception, 1);
    chk("pend_cause", cause, 4'b1101);
    chk("pend_pc", exc_pc, 32'h504);
    tick();
    do_eret(32'h504);
`else
    chk("nopend_exc", exception, 0);
    chk("nopend_busy", busy, 0);
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
